// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing
// Outputs are forced to zero while rst is high so reset takes effect without a clock edge.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        instr_done,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] C_R    = 3'b000;
  localparam logic [2:0] C_I    = 3'b001;
  localparam logic [2:0] C_B    = 3'b010;
  localparam logic [2:0] C_S    = 3'b011;
  localparam logic [2:0] C_U    = 3'b100;
  localparam logic [2:0] C_J    = 3'b101;
  localparam logic [2:0] C_LOAD = 3'b110;

  state_t      state, state_nx;
  logic [2:0]  cls;
  logic        cls_jalr;
  logic [31:0] instret_q;

  logic [2:0]  dec_cls;
  logic        dec_jalr;
  logic        dec_legal;

  always_comb begin
    dec_cls   = C_R;
    dec_jalr  = 1'b0;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_S;
      7'b1100011: dec_cls = C_B;
      7'b0110111,
      7'b0010111: dec_cls = C_U;
      7'b1101111: dec_cls = C_J;
      7'b1100111: begin
        dec_cls  = C_J;
        dec_jalr = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Class is captured once in DECODE; opcode may change after that without effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls      <= C_R;
      cls_jalr <= 1'b0;
    end else if (state == S_DECODE && dec_legal) begin
      cls      <= dec_cls;
      cls_jalr <= dec_jalr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instret_q <= 32'd0;
    else if (instr_done) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;

  always_comb begin
    state_nx   = state;
    alu_op     = 3'b000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_fetch  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    wb_sel     = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_fetch = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_nx = S_EXEC;
        end else begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op = cls;
        if (cls == C_B) begin
          pc_write   = 1'b1;
          pc_src     = branch_cond ? 2'b01 : 2'b00;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end else if (cls == C_LOAD || cls == C_S) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        alu_op  = cls;
        mem_req = 1'b1;
        mem_we  = (cls == C_S);
        if (mem_ready) begin
          if (cls == C_S) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_nx   = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        alu_op     = cls;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (cls == C_LOAD) wb_sel = 2'b01;
        else if (cls == C_J) wb_sel = 2'b10;
        if (cls == C_J) pc_src = cls_jalr ? 2'b10 : 2'b01;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
    if (rst) begin
      alu_op     = 3'b000;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_fetch  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      wb_sel     = 2'b00;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with a stalling memory responder
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_cond;
  logic        mem_ready;
  logic [2:0]  alu_op;
  logic        mem_req, mem_we, mem_fetch;
  logic        ir_write, reg_write, pc_write;
  logic [1:0]  pc_src, wb_sel;
  logic        illegal, instr_done;
  logic [31:0] instret;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .mem_fetch(mem_fetch),
    .ir_write(ir_write), .reg_write(reg_write), .pc_write(pc_write),
    .pc_src(pc_src), .wb_sel(wb_sel), .illegal(illegal), .instr_done(instr_done),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ill;
    logic [2:0]  alu;
    logic [1:0]  pcs;
    logic        pcw;
    logic        rw;
    logic [1:0]  wbs;
    logic        we;
    int          lat;
    logic [31:0] ir;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ret = 32'd0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUI = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected completion behaviour from the instruction-class table and wait counts.
  function automatic exp_t model(input logic [6:0] op, input logic bc, input int fw, input int mw);
    exp_t e;
    e = '{ill: 1'b0, alu: 3'd0, pcs: 2'd0, pcw: 1'b1, rw: 1'b0, wbs: 2'd0, we: 1'b0, lat: 0, ir: model_ret};
    case (op)
      OP_R:          begin e.alu = 3'b000; e.rw = 1'b1; e.lat = 4 + fw; end
      OP_I:          begin e.alu = 3'b001; e.rw = 1'b1; e.lat = 4 + fw; end
      OP_LUI, OP_AUI: begin e.alu = 3'b100; e.rw = 1'b1; e.lat = 4 + fw; end
      OP_LD:         begin e.alu = 3'b110; e.rw = 1'b1; e.wbs = 2'b01; e.lat = 5 + fw + mw; end
      OP_S:          begin e.alu = 3'b011; e.we = 1'b1; e.lat = 4 + fw + mw; end
      OP_B:          begin e.alu = 3'b010; e.pcs = bc ? 2'b01 : 2'b00; e.lat = 3 + fw; end
      OP_JAL:        begin e.alu = 3'b101; e.rw = 1'b1; e.wbs = 2'b10; e.pcs = 2'b01; e.lat = 4 + fw; end
      OP_JALR:       begin e.alu = 3'b101; e.rw = 1'b1; e.wbs = 2'b10; e.pcs = 2'b10; e.lat = 4 + fw; end
      default:       begin e.ill = 1'b1; e.lat = 2 + fw; end
    endcase
    return e;
  endfunction

  // Monitor: counts cycles per instruction and checks each completion against the queue head.
  initial begin
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
      end else begin
        cyc++;
        if (instr_done || illegal) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion actual=done expected=none t=%0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("illegal",   {31'd0, illegal},    {31'd0, e.ill});
            chk("done",      {31'd0, instr_done}, {31'd0, ~e.ill});
            chk("alu_op",    {29'd0, alu_op},     {29'd0, e.alu});
            chk("pc_src",    {30'd0, pc_src},     {30'd0, e.pcs});
            chk("pc_write",  {31'd0, pc_write},   {31'd0, e.pcw});
            chk("reg_write", {31'd0, reg_write},  {31'd0, e.rw});
            chk("wb_sel",    {30'd0, wb_sel},     {30'd0, e.wbs});
            chk("mem_we",    {31'd0, mem_we},     {31'd0, e.we});
            chk("mem_req",   {31'd0, mem_req},    {31'd0, e.we});
            chk("latency",   cyc,                 e.lat);
            chk("instret",   instret,             e.ir);
          end
          cyc = 0;
        end
      end
    end
  end

  // Issue one instruction; acts as memory holding off fw fetch and mw data cycles.
  task automatic run_instr(input logic [6:0] op, input logic bc, input int fw, input int mw);
    exp_t e;
    int   fc, mc, n;
    bit   done;
    e = model(op, bc, fw, mw);
    sbq.push_back(e);
    if (!e.ill) model_ret = model_ret + 32'd1;
    opcode = op;
    branch_cond = bc;
    fc = 0; mc = 0; n = 0; done = 1'b0;
    while (!done) begin
      if (mem_req && mem_fetch) begin
        if (fc < fw) begin mem_ready = 1'b0; fc++; end
        else mem_ready = 1'b1;
      end else if (mem_req) begin
        if (mc < mw) begin mem_ready = 1'b0; mc++; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      done = instr_done || illegal;
      n++;
      if (n > 200 && !done) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=%0d expected<=200 op=%b", n, op);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [6:0] ops [9];
    logic [6:0] op;
    int         n;
    ops = '{OP_R, OP_I, OP_LD, OP_S, OP_B, OP_LUI, OP_AUI, OP_JAL, OP_JALR};

    rst = 1'b1; opcode = 7'd0; branch_cond = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_ir_write",  {31'd0, ir_write},  32'd0);
    chk("rst_instret",   instret,            32'd0);
    chk("rst_outs",      {20'd0, alu_op, mem_we, mem_fetch, reg_write, pc_write, pc_src, wb_sel, illegal, instr_done}, 32'd0);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_mem_req",   {31'd0, mem_req},   32'd1);
    chk("rel_mem_fetch", {31'd0, mem_fetch}, 32'd1);

    run_instr(OP_R, 1'b0, 0, 0);
    chk("instret_after_r", instret, 32'd1);
    run_instr(OP_LD, 1'b0, 0, 3);
    run_instr(OP_B, 1'b1, 0, 0);
    run_instr(OP_B, 1'b0, 0, 0);
    run_instr(7'b1111111, 1'b0, 0, 0);
    chk("instret_after_illegal", instret, model_ret);
    run_instr(OP_JALR, 1'b0, 2, 0);
    run_instr(OP_S, 1'b0, 1, 2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 8)];
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abort a store while it waits in MEM.
    opcode = OP_S; branch_cond = 1'b0; mem_ready = 1'b1;
    n = 0;
    while (!(mem_req && !mem_fetch) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    mem_ready = 1'b0;
    chk("abort_in_mem", {30'd0, mem_req, mem_we}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_mem_we",  {31'd0, mem_we},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_ret = 32'd0;
    #1;
    chk("abort_instret", instret, 32'd0);
    chk("abort_fetch",   {30'd0, mem_req, mem_fetch}, 32'd3);
    run_instr(OP_S, 1'b0, 0, 1);

    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_ret = 32'hFFFF_FFFF;
    run_instr(OP_I, 1'b0, 0, 0);
    chk("instret_wrap", instret, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
